// File: rtl/cla_adder_design.sv
// ---------------------------------------------------------------------------
// cla_adder_design
//
// Purpose
//   Registered two-level carry-lookahead adder. Operands are split into
//   WIDTH/4 four-bit groups. Each group derives its internal carries from
//   bit generate/propagate terms and its own group carry-in using flat
//   lookahead equations. A second-level unit derives every group carry-in
//   directly from the group generate/propagate values and cin. Carries never
//   ripple, either inside a group or between groups. The sum, the block
//   propagate and the block generate are captured one cycle after in_valid.
//
// Parameters
//   WIDTH     operand width in bits; must be a positive multiple of 4.
//
// Ports
//   clk       in   1        clock, rising edge active
//   rst       in   1        asynchronous, active-high reset
//   in_valid  in   1        a, b and cin are meaningful this cycle
//   a         in   WIDTH    unsigned operand A
//   b         in   WIDTH    unsigned operand B
//   cin       in   1        carry-in at bit 0
//   result    out  WIDTH+1  registered sum, MSB is the carry-out
//   out_valid out  1        result holds a freshly captured sum this cycle
//   group_p   out  1        registered AND of all bit propagates
//   group_g   out  1        registered carry-out of a + b with cin forced to 0
//
// Handshake
//   Valid-only, no backpressure: there is no ready signal and the block
//   accepts every cycle. A rising edge that samples in_valid=1 loads result,
//   group_p and group_g and raises out_valid for exactly the following cycle.
//   A rising edge that samples in_valid=0 clears out_valid and leaves the
//   data outputs holding their previous values. Back-to-back valid inputs
//   produce back-to-back out_valid pulses in the same order. Reset clears
//   everything at once, so a sum in flight when rst rises is discarded.
// ---------------------------------------------------------------------------
module cla_adder_design #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   result,
  output logic             out_valid,
  output logic             group_p,
  output logic             group_g
);

  localparam int NG = WIDTH / 4;

  // Bit-level terms.
  logic [WIDTH-1:0] g;      // generate  g[i] = a[i] & b[i]
  logic [WIDTH-1:0] p;      // propagate p[i] = a[i] ^ b[i]
  logic [WIDTH-1:0] c;      // carry into bit i
  logic [WIDTH-1:0] s;      // sum bits

  // Group-level terms.
  logic [NG-1:0]    gg;     // group generate
  logic [NG-1:0]    gp;     // group propagate
  logic [NG-1:0]    gc;     // group carry-in from the second level

  // Block-level terms.
  logic             cout;   // carry into bit WIDTH
  logic             blk_g;  // carry-out with cin forced to 0
  logic             blk_p;  // every bit propagates
  logic [WIDTH:0]   sum;

  assign g = a & b;
  assign p = a ^ b;

  // -------------------------------------------------------------------------
  // First level: one lookahead block per 4-bit group. Each carry is written
  // as a sum of products over the group's g/p terms and the group carry-in,
  // so no carry depends on another carry inside the group.
  // -------------------------------------------------------------------------
  for (genvar k = 0; k < NG; k++) begin : g_group
    localparam int B = 4 * k;

    logic c0;
    assign c0 = gc[k];

    assign c[B]   = c0;
    assign c[B+1] = g[B]
                  | (p[B] & c0);
    assign c[B+2] = g[B+1]
                  | (p[B+1] & g[B])
                  | (p[B+1] & p[B] & c0);
    assign c[B+3] = g[B+2]
                  | (p[B+2] & g[B+1])
                  | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c0);

    // Group carry-out would be gg | gp & c0; the second level computes it
    // in flat form instead, so only GG/GP leave the group.
    assign gp[k] = p[B+3] & p[B+2] & p[B+1] & p[B];
    assign gg[k] = g[B+3]
                 | (p[B+3] & g[B+2])
                 | (p[B+3] & p[B+2] & g[B+1])
                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);
  end

  // -------------------------------------------------------------------------
  // Second level: carry into group n as a flat sum of products
  //   C(n) = GG[n-1] | GP[n-1]GG[n-2] | ... | GP[n-1]..GP[0]c0
  // Each call is evaluated with a constant n, so every group carry is an
  // independent two-level expression rather than a chain through C(n-1).
  // With a single group C(0) is just c0 and C(1) is the block carry-out.
  // -------------------------------------------------------------------------
  function automatic logic lookahead(input logic [NG-1:0] ggv,
                                     input logic [NG-1:0] gpv,
                                     input logic          c0,
                                     input int            n);
    logic carry;
    logic term;
    carry = 1'b0;
    for (int j = 0; j < n; j++) begin
      term = ggv[j];
      for (int m = j + 1; m < n; m++) begin
        term = term & gpv[m];
      end
      carry = carry | term;
    end
    term = c0;
    for (int m = 0; m < n; m++) begin
      term = term & gpv[m];
    end
    carry = carry | term;
    return carry;
  endfunction

  always_comb begin
    gc = '0;
    for (int k = 0; k < NG; k++) begin
      gc[k] = lookahead(gg, gp, cin, k);
    end
  end

  assign cout  = lookahead(gg, gp, cin,  NG);
  assign blk_g = lookahead(gg, gp, 1'b0, NG);
  assign blk_p = &gp;

  assign s   = p ^ c;
  assign sum = {cout, s};

  // -------------------------------------------------------------------------
  // Output register. Data outputs only load on an accepted input, so they
  // hold across gaps in in_valid; out_valid simply mirrors the last sample.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      out_valid <= 1'b0;
      group_p   <= 1'b0;
      group_g   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result  <= sum;
        group_p <= blk_p;
        group_g <= blk_g;
      end
    end
  end

endmodule

// File: tb/tb_cla_adder_design.sv
// ---------------------------------------------------------------------------
// tb_cla_adder_design
//
// Drives a 4-bit and a 16-bit instance of cla_adder_design from a shared
// in_valid. Expected {result, group_p, group_g} tuples are computed with
// plain wide arithmetic, pushed when an input is driven valid, and popped
// when the DUT raises out_valid. Directed vectors cover reset, latency,
// group flags, carry boundaries, valid gaps and a mid-stream reset; a long
// random run follows.
// ---------------------------------------------------------------------------
module tb_cla_adder_design;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        cin4 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        cin16 = 1'b0;

  logic [4:0]  result4;
  logic        out_valid4, group_p4, group_g4;
  logic [16:0] result16;
  logic        out_valid16, group_p16, group_g16;

  cla_adder_design #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
    .result    (result4),
    .out_valid (out_valid4),
    .group_p   (group_p4),
    .group_g   (group_g4)
  );

  cla_adder_design #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a16),
    .b         (b16),
    .cin       (cin16),
    .result    (result16),
    .out_valid (out_valid16),
    .group_p   (group_p16),
    .group_g   (group_g16)
  );

  // ---------------- scoreboard ----------------
  // Packed as {result, group_p, group_g}.
  logic [6:0]  exp4_q[$];
  logic [18:0] exp16_q[$];
  logic [6:0]  last4  = '0;
  logic [18:0] last16 = '0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] model4(input logic [3:0] x, input logic [3:0] y,
                                        input logic ci);
    logic [4:0] s;
    logic [4:0] s_nc;
    s    = {1'b0, x} + {1'b0, y} + {4'b0, ci};
    s_nc = {1'b0, x} + {1'b0, y};
    return {s, &(x ^ y), s_nc[4]};
  endfunction

  function automatic logic [18:0] model16(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci);
    logic [16:0] s;
    logic [16:0] s_nc;
    s    = {1'b0, x} + {1'b0, y} + {16'b0, ci};
    s_nc = {1'b0, x} + {1'b0, y};
    return {s, &(x ^ y), s_nc[16]};
  endfunction

  // Compare the visible outputs against the last accepted tuple.
  task automatic check_outputs();
    check("res4",  result4,   last4[6:2]);
    check("gp4",   group_p4,  last4[1]);
    check("gg4",   group_g4,  last4[0]);
    check("res16", result16,  last16[18:2]);
    check("gp16",  group_p16, last16[1]);
    check("gg16",  group_g16, last16[0]);
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; drives one cycle of stimulus and checks
  // the outputs shortly after the next rising edge.
  task automatic step(input logic v,
                      input logic [3:0] xa4, input logic [3:0] xb4, input logic xc4,
                      input logic [15:0] xa16, input logic [15:0] xb16, input logic xc16);
    in_valid = v;
    a4 = xa4;   b4 = xb4;   cin4 = xc4;
    a16 = xa16; b16 = xb16; cin16 = xc16;
    if (v) begin
      exp4_q.push_back(model4(xa4, xb4, xc4));
      exp16_q.push_back(model16(xa16, xb16, xc16));
    end
    @(posedge clk);
    #1;
    check("vld4",  out_valid4,  v);
    check("vld16", out_valid16, v);
    if (out_valid4) begin
      check("q4_size", exp4_q.size(), 1);
      if (exp4_q.size() != 0) last4 = exp4_q.pop_front();
    end
    if (out_valid16) begin
      check("q16_size", exp16_q.size(), 1);
      if (exp16_q.size() != 0) last16 = exp16_q.pop_front();
    end
    check_outputs();
    // Anything left over was never delivered.
    check("q4_left",  exp4_q.size(),  0);
    check("q16_left", exp16_q.size(), 0);
    exp4_q.delete();
    exp16_q.delete();
  endtask

  task automatic step_rand(input logic v);
    step(v, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
         16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
         1'($urandom_range(0, 1)));
  endtask

  // ---------------- sequence ----------------
  initial begin
    // Reset state, including posedges seen with in_valid=1 during reset.
    #2;
    check_outputs();
    check("rst_vld4",  out_valid4,  1'b0);
    check("rst_vld16", out_valid16, 1'b0);
    in_valid = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    check_outputs();
    check("rst_vld4b", out_valid4, 1'b0);
    rst = 1'b0;

    // First edge after reset release accepts input; 1-cycle latency.
    step(1'b1, 4'b1000, 4'b1010, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
    // Group generate set, propagate clear.
    step(1'b1, 4'b1100, 4'b1000, 1'b0, 16'hC000, 16'h8000, 1'b0);
    // Carry through every group; group propagate set.
    step(1'b1, 4'b1111, 4'b0000, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
    // All ones + all ones + 1.
    step(1'b1, 4'b1111, 4'b1111, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    // Zero.
    step(1'b1, 4'b0000, 4'b0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
    // Alternating propagate patterns.
    step(1'b1, 4'b0101, 4'b1010, 1'b1, 16'h5A5A, 16'hA5A5, 1'b1);
    step(1'b1, 4'b0111, 4'b0001, 1'b0, 16'h0FFF, 16'h0001, 1'b0);

    // Three valid, one gap (outputs hold), one valid.
    step(1'b1, 4'd3, 4'd4, 1'b0, 16'd1000, 16'd2000, 1'b1);
    step(1'b1, 4'd9, 4'd9, 1'b1, 16'hF0F0, 16'h0F0F, 1'b1);
    step(1'b1, 4'd6, 4'd2, 1'b0, 16'h8000, 16'h8000, 1'b0);
    step_rand(1'b0);
    step(1'b1, 4'd15, 4'd1, 1'b0, 16'h1234, 16'h4321, 1'b0);

    // Asynchronous reset between edges while out_valid=1.
    #3;
    rst = 1'b1;
    #1;
    last4 = '0;
    last16 = '0;
    check_outputs();
    check("arst_vld4",  out_valid4,  1'b0);
    check("arst_vld16", out_valid16, 1'b0);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
    check("arst_vld4b", out_valid4, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    step_rand(1'b0);
    step_rand(1'b0);
    step(1'b1, 4'd7, 4'd8, 1'b1, 16'hFFFE, 16'h0001, 1'b1);

    // Random run with occasional gaps.
    for (int i = 0; i < 10500; i++) begin
      step_rand(1'($urandom_range(0, 7) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cla_adder_design.md
CLA_ADDER_DESIGN -- requirements
Module: cla_adder_design

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; SHALL be a positive multiple of 4.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, asynchronous and active-high.
REQ-004 Port in_valid  input  1  qualifies a, b, cin in the current cycle.
REQ-005 Port a  input  WIDTH  unsigned operand A.
REQ-006 Port b  input  WIDTH  unsigned operand B.
REQ-007 Port cin  input  1  carry-in added at bit 0.
REQ-008 Port result  output  WIDTH+1  registered sum; MSB is the carry-out.
REQ-009 Port out_valid  output  1  result holds a new sum this cycle.
REQ-010 Port group_p  output  1  registered block propagate: AND of all bit propagates of the captured operands.
REQ-011 Port group_g  output  1  registered block generate: carry-out of the captured operands with cin forced to 0.

Function
REQ-012 Bit terms: generate g[i] = a[i] AND b[i]; propagate p[i] = a[i] XOR b[i].
REQ-013 Operands SHALL be split into WIDTH/4 4-bit groups.
- Each group computes internal carries with lookahead equations from g, p and its group carry-in.
- c1 = g0 | p0·c0; c2 = g1 | p1·g0 | p1·p0·c0; likewise for c3 and c4.
- No ripple chain is permitted inside a group.
REQ-014 Each group SHALL produce a group generate GG and a group propagate GP.
REQ-015 A second-level lookahead unit SHALL compute every group carry-in from the GG/GP values and cin.
- Carries SHALL NOT ripple between groups.
- When WIDTH=4, the second level reduces to one group.
REQ-016 Sum bit s[i] = p[i] XOR c[i]; carry-out = carry into bit WIDTH.
REQ-017 The combinational sum SHALL equal a + b + cin, exactly, modulo 2^(WIDTH+1); no truncation is permitted.
REQ-018 Latency is 1 cycle.
- On a rising edge with in_valid=1: result, group_p and group_g load the values for the current a, b, cin; out_valid is set to 1.
REQ-019 On a rising edge with in_valid=0: out_valid goes to 0, and result, group_p and group_g hold their previous values.
REQ-020 Back-to-back: in_valid held high for N cycles SHALL yield N consecutive out_valid pulses, in order, with no bubbles.
REQ-021 Boundary cases, all exact:
- all-ones + all-ones + cin=1: result = all ones (2^(WIDTH+1)-1).
- all-ones + 0 + cin=1: result = 2^WIDTH; carry propagates through every group.
- 0 + 0 + 0: result = 0.
REQ-022 group_p = 1 when a XOR b is all ones; group_g = 1 when a + b ≥ 2^WIDTH.

Reset
REQ-023 While rst=1, regardless of clk: result = 0, out_valid = 0, group_p = 0, group_g = 0.
REQ-024 Reset asserted mid-stream SHALL discard the in-flight sum.
- After rst deasserts, no out_valid SHALL occur until the first rising edge that samples in_valid=1.
REQ-025 in_valid=1 on the first rising edge after rst deasserts SHALL be accepted normally.

Verification (WIDTH=4 unless noted)
REQ-026 a=1000, b=1010, cin=0, in_valid=1 -> next cycle: result=10010, out_valid=1.
REQ-027 a=1100, b=1000, cin=0 -> result=10100; group_g=1; group_p=0.
REQ-028 a=1111, b=0000, cin=1 -> result=10000, group_p=1; a=1111, b=1111, cin=1 -> result=11111.
REQ-029 Sequence of 3 valid inputs, in_valid gap, 1 valid input -> out_valid pattern 1,1,1,0,1; result holds during the gap.
REQ-030 rst pulsed asynchronously between clock edges while out_valid=1 -> result=0 and out_valid=0 immediately; after rst deasserts, out_valid stays 0 until in_valid=1 is sampled.
REQ-031 WIDTH=16, exhaustive random (≥10000 vectors) -> result == a+b+cin every valid cycle; includes a=FFFF, b=0001, cin=0 -> result=10000 hex.
